// File: rtl/imem_loader_pkg.sv
// Shared processor package: loader FSM state encoding and word/address constants.
package imem_loader_pkg;

  // Loader FSM state encoding
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_COLLECT = 3'd1;
  localparam logic [2:0] ST_WRITE   = 3'd2;
  localparam logic [2:0] ST_CHECK   = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  // Bytes assembled into one IMEM word, and byte-address step between words
  localparam int         BYTES_PER_WORD = 4;
  localparam logic [7:0] ADDR_STEP      = 8'd4;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: big-endian byte-to-word shift register for the IMEM loader.
// The first accepted byte ends up in bits [31:24]. almost_full flags that the
// next accepted byte completes the word, so the FSM can move on the same edge.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_in,
  input  logic        accept,
  input  logic        clear,
  output logic [31:0] word,
  output logic        word_full,
  output logic        almost_full
);

  localparam logic [2:0] FULL_CNT = 3'(BYTES_PER_WORD);

  logic [2:0] count;

  // Shift accepted bytes in from the right; clear wins over accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 3'd0;
      word  <= 32'd0;
    end else if (clear) begin
      count <= 3'd0;
      word  <= 32'd0;
    end else if (accept && (count != FULL_CNT)) begin
      word  <= {word[23:0], byte_in};
      count <= count + 3'd1;
    end
  end

  assign word_full   = (count == FULL_CNT);
  assign almost_full = (count == (FULL_CNT - 3'd1));

endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams bytes into 32-bit words and writes them to a 256-byte
// IMEM starting at a base byte address, wrapping modulo 256.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to XOR-accumulate written
// words and compare against a trailing 4-byte checksum word (IMLD_error).
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int WORD_COUNT_MAX = 64
) (
  input  logic        SYS_clk,
  input  logic        SYS_reset,
  input  logic        IMLD_start,
  input  logic [7:0]  IMLD_base_addr,
  input  logic [6:0]  IMLD_word_count,
  input  logic [7:0]  IMLD_byte_in,
  input  logic        IMLD_byte_valid,
  output logic        IMLD_byte_ready,
  output logic [7:0]  IMLD_mem_addr,
  output logic [31:0] IMLD_mem_data,
  output logic        IMLD_mem_write,
  output logic        IMLD_busy,
  output logic        IMLD_done,
  output logic        IMLD_error
);

  // The count port is 7 bits wide, so anything above 127 can never be exceeded
  localparam int         MAX_CLAMP = (WORD_COUNT_MAX > 127) ? 127 : WORD_COUNT_MAX;
  localparam logic [6:0] MAX_CNT   = 7'(MAX_CLAMP);

  logic [2:0]  state;
  logic [7:0]  addr;
  logic [6:0]  remaining;
  logic [7:0]  held_addr;
  logic [31:0] held_data;

  logic        start_ok;
  logic        count_ok;
  logic        accept;
  logic        clear;
  logic [31:0] word;
  logic        word_full;
  logic        almost_full;

  assign start_ok = IMLD_start && (state == ST_IDLE);
  assign count_ok = (IMLD_word_count != 7'd0) && (IMLD_word_count <= MAX_CNT);

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign IMLD_byte_ready = (state == ST_COLLECT) || (state == ST_CHECK);
`else
  assign IMLD_byte_ready = (state == ST_COLLECT);
`endif

  assign accept = IMLD_byte_valid && IMLD_byte_ready;
  // Fresh word on a new load, after each write, and after the checksum word
  assign clear  = start_ok || (state == ST_WRITE) || (state == ST_DONE);

  byte_packer u_packer (
    .clk        (SYS_clk),
    .rst        (SYS_reset),
    .byte_in    (IMLD_byte_in),
    .accept     (accept),
    .clear      (clear),
    .word       (word),
    .word_full  (word_full),
    .almost_full(almost_full)
  );

  // Memory port shows the live word while writing, the last write otherwise
  assign IMLD_mem_write = (state == ST_WRITE) && word_full;
  assign IMLD_mem_addr  = IMLD_mem_write ? addr : held_addr;
  assign IMLD_mem_data  = IMLD_mem_write ? word : held_data;
  assign IMLD_busy      = (state != ST_IDLE);
  assign IMLD_done      = (state == ST_DONE);

  // Load sequencing FSM with address and remaining-word bookkeeping
  always_ff @(posedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      state     <= ST_IDLE;
      addr      <= 8'd0;
      remaining <= 7'd0;
      held_addr <= 8'd0;
      held_data <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            addr      <= IMLD_base_addr;
            remaining <= IMLD_word_count;
            state     <= count_ok ? ST_COLLECT : ST_DONE;
          end
        end
        ST_COLLECT: begin
          if (accept && almost_full) state <= ST_WRITE;
        end
        ST_WRITE: begin
          held_addr <= addr;
          held_data <= word;
          addr      <= addr + ADDR_STEP;
          remaining <= remaining - 7'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          state     <= (remaining > 7'd1) ? ST_COLLECT : ST_CHECK;
`else
          state     <= (remaining > 7'd1) ? ST_COLLECT : ST_DONE;
`endif
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (accept && almost_full) state <= ST_DONE;
        end
`endif
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] csum;
  logic        error_flag;

  // XOR of written words; error latched as the checksum word completes
  always_ff @(posedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      csum       <= 32'd0;
      error_flag <= 1'b0;
    end else if (start_ok) begin
      csum       <= 32'd0;
      error_flag <= 1'b0;
    end else if (state == ST_WRITE) begin
      csum       <= csum ^ word;
    end else if ((state == ST_CHECK) && accept && almost_full) begin
      error_flag <= (csum != {word[23:0], IMLD_byte_in});
    end
  end

  assign IMLD_error = error_flag;
`else
  assign IMLD_error = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader. Expected writes and done pulses are pushed
// by the stimulus side from a word-list model; a negedge monitor pops them.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  base_addr = 8'd0;
  logic [6:0]  word_count = 7'd0;
  logic [7:0]  byte_in = 8'd0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic [7:0]  mem_addr;
  logic [31:0] mem_data;
  logic        mem_write;
  logic        busy;
  logic        done;
  logic        error;

  imem_loader #(.WORD_COUNT_MAX(64)) dut (
    .SYS_clk        (clk),
    .SYS_reset      (rst),
    .IMLD_start     (start),
    .IMLD_base_addr (base_addr),
    .IMLD_word_count(word_count),
    .IMLD_byte_in   (byte_in),
    .IMLD_byte_valid(byte_valid),
    .IMLD_byte_ready(byte_ready),
    .IMLD_mem_addr  (mem_addr),
    .IMLD_mem_data  (mem_data),
    .IMLD_mem_write (mem_write),
    .IMLD_busy      (busy),
    .IMLD_done      (done),
    .IMLD_error     (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_done;
    logic [7:0]  addr;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] wbuf[$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write and done pulse must match the head of the scoreboard
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (mem_write) begin
        if (sbq.size() == 0 || sbq[0].is_done) begin
          checks++; errors++;
          $display("FAIL unexpected_write: addr %h data %h at %0t", mem_addr, mem_data, $time);
        end else begin
          e = sbq.pop_front();
          chk("wr_addr", mem_addr, e.addr);
          chk("wr_data", mem_data, e.data);
        end
      end
      if (done) begin
        if (sbq.size() == 0 || !sbq[0].is_done) begin
          checks++; errors++;
          $display("FAIL unexpected_done: at %0t", $time);
        end else begin
          e = sbq.pop_front();
          chk("done_error", error, e.err);
        end
      end
    end
  end

  // Present one byte until the handshake accepts it
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    byte_in    = b;
    byte_valid = 1'b1;
    while (!byte_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL byte_timeout: ready never rose at %0t", $time);
    end
    @(posedge clk);
    #1 byte_valid = 1'b0;
  endtask

  // Model expectations from wbuf and drive one complete load
  task automatic do_load(input logic [7:0] base, input bit gap, input logic [31:0] csum_delta,
                         input bit inject_start);
    int          n;
    logic [31:0] x;
    logic [31:0] w;
    exp_t        e;
    n = wbuf.size();
    x = 32'd0;
    for (int i = 0; i < n; i++) begin
      e.is_done = 1'b0;
      e.addr    = 8'((int'(base) + 4 * i) % 256);
      e.data    = wbuf[i];
      e.err     = 1'b0;
      sbq.push_back(e);
      x = x ^ wbuf[i];
    end
    e.is_done = 1'b1;
    e.addr    = 8'd0;
    e.data    = 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    e.err     = (csum_delta != 32'd0);
`else
    e.err     = 1'b0;
`endif
    sbq.push_back(e);

    @(negedge clk);
    start      = 1'b1;
    base_addr  = base;
    word_count = 7'(n);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("error_cleared", error, 0);

    for (int i = 0; i < n; i++) begin
      w = wbuf[i];
      for (int b = 0; b < 4; b++) begin
        if (inject_start && i == 0 && b == 1) begin
          start      = 1'b1;
          base_addr  = ~base;
          word_count = 7'd1;
        end
        send_byte(w[31 - 8 * b -: 8]);
        start = 1'b0;
        if (gap && b < 3) @(posedge clk);
      end
      @(negedge clk);
      chk("write_latency", mem_write, 1);
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    w = x ^ csum_delta;
    for (int b = 0; b < 4; b++) send_byte(w[31 - 8 * b -: 8]);
`endif
    @(negedge clk);
    chk("done_timing", done, 1);
    @(negedge clk);
    chk("idle_after_done", busy, 0);
  endtask

  // Start with an out-of-range count: immediate done, no writes
  task automatic empty_load(input logic [6:0] cnt);
    exp_t e;
    e.is_done = 1'b1;
    e.addr    = 8'd0;
    e.data    = 32'd0;
    e.err     = 1'b0;
    sbq.push_back(e);
    @(negedge clk);
    start      = 1'b1;
    base_addr  = 8'h44;
    word_count = cnt;
    @(negedge clk);
    chk("empty_done", done, 1);
    // start held into the DONE cycle must be ignored
    word_count = 7'd1;
    @(negedge clk);
    start = 1'b0;
    chk("empty_ignored_busy", busy, 0);
    chk("empty_ignored_done", done, 0);
  endtask

  task automatic rand_words(input int n);
    wbuf.delete();
    for (int i = 0; i < n; i++) wbuf.push_back($urandom);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] d;
    #1 rst = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_write", mem_write, 0);
    chk("rst_ready", byte_ready, 0);
    chk("rst_error", error, 0);
    repeat (2) @(negedge clk);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", mem_data, 0);
    rst = 1'b0;

    // Bytes offered while idle must not be consumed
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      byte_in    = 8'($urandom);
      byte_valid = 1'b1;
      chk("idle_ready", byte_ready, 0);
    end
    @(negedge clk);
    byte_valid = 1'b0;

    // Single word, gapless
    wbuf.delete();
    wbuf.push_back(32'h8C010004);
    do_load(8'h00, 1'b0, 32'd0, 1'b0);
    chk("held_addr", mem_addr, 32'h00);
    chk("held_data", mem_data, 32'h8C010004);

    // Address wrap at the top of the IMEM
    rand_words(3);
    do_load(8'hF8, 1'b0, 32'd0, 1'b0);

    // Same two words, gapless then with valid toggling
    rand_words(2);
    do_load(8'h40, 1'b0, 32'd0, 1'b0);
    do_load(8'h40, 1'b1, 32'd0, 1'b0);

    // Start during COLLECT is ignored
    rand_words(2);
    do_load(8'h10, 1'b0, 32'd0, 1'b1);

    // Zero and oversize counts
    empty_load(7'd0);
    empty_load(7'd65);

    // Largest accepted count
    rand_words(64);
    do_load(8'h80, 1'b0, 32'd0, 1'b0);

    // Reset in the middle of word 1
    @(negedge clk);
    start      = 1'b1;
    base_addr  = 8'h20;
    word_count = 7'd2;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'hAA);
    send_byte(8'hBB);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", byte_ready, 0);
    chk("midrst_addr", mem_addr, 0);
    chk("midrst_data", mem_data, 0);
    chk("midrst_write", mem_write, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst_no_done", done, 0);
    wbuf.delete();
    wbuf.push_back(32'hCAFEF00D);
    do_load(8'h30, 1'b0, 32'd0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    wbuf.delete();
    wbuf.push_back(32'h11111111);
    wbuf.push_back(32'h22222222);
    do_load(8'h00, 1'b0, 32'h00000000, 1'b0);
    do_load(8'h00, 1'b0, 32'h00000003, 1'b0);
    repeat (3) @(negedge clk);
    chk("error_holds", error, 1);
`endif

    // Randomized loads
    for (int t = 0; t < 10; t++) begin
      rand_words(int'($urandom_range(1, 5)));
      d = ($urandom_range(0, 1) == 1) ? $urandom : 32'd0;
      do_load(8'($urandom), bit'($urandom_range(0, 1)), d, 1'b0);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter WORD_COUNT_MAX, default 64, meaning the largest accepted word count (256-byte IMEM / 4).
REQ-002 The block SHALL have port SYS_clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port SYS_reset  input  1  reset; asynchronous, active-high.
REQ-004 The block SHALL have port IMLD_start  input  1  one-cycle request to begin a load.
REQ-005 The block SHALL have port IMLD_base_addr  input  8  byte address of the first word; sampled on an accepted start.
REQ-006 The block SHALL have port IMLD_word_count  input  7  number of words to load; sampled on an accepted start.
REQ-007 The block SHALL have port IMLD_byte_in  input  8  incoming instruction byte.
REQ-008 The block SHALL have port IMLD_byte_valid  input  1  IMLD_byte_in is valid.
REQ-009 The block SHALL have port IMLD_byte_ready  output  1  loader accepts a byte this cycle.
REQ-010 The block SHALL have port IMLD_mem_addr  output  8  IMEM write byte address.
REQ-011 The block SHALL have port IMLD_mem_data  output  32  IMEM write data.
REQ-012 The block SHALL have port IMLD_mem_write  output  1  IMEM write strobe.
REQ-013 The block SHALL have port IMLD_busy  output  1  high while a load is in progress.
REQ-014 The block SHALL have port IMLD_done  output  1  one-cycle pulse when a load completes.
REQ-015 The block SHALL have port IMLD_error  output  1  checksum mismatch flag.

Function
REQ-016 The FSM SHALL have states IDLE, COLLECT, WRITE, CHECK and DONE.
REQ-017 In IDLE an IMLD_start pulse SHALL latch the base address and word count; with a count of 1..WORD_COUNT_MAX the FSM goes to COLLECT and IMLD_error clears.
REQ-018 A word count of 0, or greater than WORD_COUNT_MAX, SHALL go directly to DONE with no memory writes.
REQ-019 IMLD_byte_ready SHALL be 1 only in COLLECT and CHECK, and a byte SHALL be accepted only when IMLD_byte_valid and IMLD_byte_ready are both 1 in the same cycle.
REQ-020 Bytes SHALL be assembled big-endian: the first accepted byte goes to bits [31:24] and the fourth to bits [7:0].
REQ-021 The cycle after the fourth byte is accepted, the FSM SHALL be in WRITE with IMLD_mem_write=1 for exactly one cycle, IMLD_mem_addr equal to the current address, and IMLD_mem_data equal to the assembled word.
REQ-022 On leaving WRITE the address SHALL increment by 4 modulo 256 (0xFC wraps to 0x00) and the remaining word count SHALL decrement by 1.
REQ-023 From WRITE the FSM SHALL go to COLLECT if words remain, otherwise to CHECK when IMEM_LOADER_CHECKSUM_EN is defined, otherwise to DONE.
REQ-024 In DONE IMLD_done SHALL be 1 for one cycle, and the FSM SHALL return to IDLE on the next edge.
REQ-025 IMLD_busy SHALL be 1 in every state except IDLE.
REQ-026 An IMLD_start arriving in any state other than IDLE SHALL be ignored.
REQ-027 IMLD_byte_valid asserted in IDLE, WRITE or DONE SHALL NOT be consumed, because ready is 0 in those states.
REQ-028 IMLD_mem_addr and IMLD_mem_data SHALL hold their last values when IMLD_mem_write=0.
REQ-029 Minimum throughput SHALL be 5 cycles per word.

Reset
REQ-030 On SYS_reset=1, immediately and regardless of clock, the FSM SHALL enter IDLE and all outputs, the byte counter, the address, the remaining count and the checksum SHALL become 0.
REQ-031 A reset during a load SHALL abandon it; a partially assembled word SHALL NOT be written and no done pulse SHALL follow.

Configuration
REQ-032 With macro IMEM_LOADER_CHECKSUM_EN defined, the block SHALL XOR-accumulate every written word and, in CHECK, collect one further 4-byte word that is not written to memory.
REQ-033 With the macro defined, IMLD_error SHALL be set to 1 in DONE if the accumulated XOR differs from the received word, and SHALL hold that value until the next accepted start or reset.
REQ-034 Without the macro, the CHECK state and the accumulator SHALL be absent and IMLD_error SHALL be tied to 0.

Structure
REQ-035 The FSM state encoding and the constants BYTES_PER_WORD=4 and ADDR_STEP=4 SHALL live in the shared processor package.
REQ-036 The byte-to-word shift register SHALL be a sub-module named byte_packer, which takes the byte, an accept strobe and a clear, and outputs the word and a word_full flag.
REQ-037 The FSM and the address/count logic SHALL stay in imem_loader.

Verification
REQ-038 Base 0x00, count 1, bytes 8C,01,00,04 sent back-to-back -> one write of 0x8C010004 at address 0x00, then done one cycle later.
REQ-039 Base 0xF8, count 3 -> writes at 0xF8, 0xFC and 0x00 (address wrap).
REQ-040 Count 2 with byte_valid toggled every other cycle -> the same two words as the gapless case, and no write until each word is complete.
REQ-041 Count 0 -> done pulse 1 cycle after start, no mem_write; a start issued while busy is ignored.
REQ-042 Reset asserted after the 2nd byte of word 1 -> outputs are 0 immediately, no write occurs, and the next load starts a fresh word.
REQ-043 With IMEM_LOADER_CHECKSUM_EN, words 0x11111111 and 0x22222222 followed by checksum 0x33333333 -> error 0; the same words with checksum 0x33333330 -> error 1, and 2 writes in each case.
